mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory word width.
REQ-003 SHALL have parameter LEN_WIDTH, default 4, burst length field width.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  input  1  clock; all state updates on posedge clk.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-007 cmd_wr  input  1  1 = write burst, 0 = read burst.
REQ-008 cmd_addr  input  ADDR_WIDTH  start address.
REQ-009 cmd_len  input  LEN_WIDTH  beats minus one.
REQ-010 wd_valid / wd_ready / wd_data  input / output / input  1 / 1 / DATA_WIDTH  write data channel.
REQ-011 rd_valid / rd_ready / rd_data / rd_last  output / input / output / output  1 / 1 / DATA_WIDTH / 1  read response channel.
REQ-012 mem_cen  output  1  active-low memory chip enable.
REQ-013 mem_wr_en / mem_addr / mem_wdata  output  1 / ADDR_WIDTH / DATA_WIDTH  memory write enable, address, write data.
REQ-014 mem_rdata  input  DATA_WIDTH  memory read data, valid the cycle after a read is sampled.

Function
REQ-015 SHALL drive all mem_* outputs from registers; no combinational path from host inputs to mem_*.
REQ-016 SHALL implement FSM IDLE, WRITE, READ, DRAIN; cmd_ready=1 only in IDLE.
REQ-017 IDLE: on cmd handshake, latch addr and beat count (cmd_len+1); go to WRITE if cmd_wr, else READ.
REQ-018 WRITE: wd_ready=1; each wd handshake registers mem_cen=0, mem_wr_en=1, mem_addr=current addr, mem_wdata=wd_data for the next cycle; after the last beat go to IDLE.
REQ-019 READ: issue one read (mem_cen=0, mem_wr_en=0) per cycle only while FIFO occupancy plus in-flight reads < 4; after the last issue go to DRAIN.
REQ-020 Every beat not driving an access SHALL register mem_cen=1, mem_wr_en=0.
REQ-021 Read data SHALL be captured from mem_rdata 2 cycles after the issue decision, via a valid pipeline, and pushed into the 4-deep response FIFO with its last flag.
REQ-022 DRAIN: go to IDLE when in-flight count is 0; FIFO may still hold data.
REQ-023 rd_valid = FIFO not empty; pop on rd_valid && rd_ready; rd_last=1 only on the final beat of a burst.
REQ-024 Address increments by 1 per beat, modulo 2^ADDR_WIDTH (wrap 63 -> 0 at default).
REQ-025 The FIFO SHALL never overflow; rd_ready held low stalls issue, not data.
REQ-026 Push and pop in the same cycle SHALL keep occupancy unchanged.

Reset
REQ-027 While rst=1: mem_cen=1, mem_wr_en=0, mem_addr=0, mem_wdata=0, cmd_ready=0, wd_ready=0, rd_valid=0, rd_last=0; FSM=IDLE.
REQ-028 Reset mid-burst SHALL abort the burst, flush the FIFO, and discard in-flight reads; cmd_ready=1 the first cycle after rst falls.

Configuration
REQ-029 Macro MEM_ACCESS_CTRL_BURST_EN defined: cmd_len honoured as in REQ-017.
REQ-030 Macro MEM_ACCESS_CTRL_BURST_EN undefined: cmd_len ignored, every command is one beat, and rd_last is always 1.

Structure
REQ-031 Shared package mem_ctrl_pkg SHALL hold the FSM state encoding and the FIFO depth constant (4).
REQ-032 Response buffer SHALL be sub-module mem_resp_fifo, a 4-deep synchronous FIFO with push, pop, full, empty, and a 3-bit count.

Verification
REQ-033 Write then read: write burst addr=5, len=3, data 0xA0..0xA3; read addr=5, len=3 -> rd_data 0xA0,0xA1,0xA2,0xA3 with rd_last on 0xA3.
REQ-034 Wrap: write addr=62, len=3 -> mem_addr sequence 62,63,0,1; read-back matches.
REQ-035 Backpressure: read len=15 with rd_ready=0 -> at most 4 reads issued, mem_cen stays high thereafter; releasing rd_ready completes all 16 beats in order.
REQ-036 Write stall: wd_valid toggles every other cycle -> one mem write per accepted beat, mem_cen=1 on idle cycles.
REQ-037 Reset mid-read: assert rst during beat 2 of a len=7 read -> rd_valid=0 and mem_cen=1 next cycle, cmd_ready=1 after rst falls.
REQ-038 Burst disabled: without MEM_ACCESS_CTRL_BURST_EN, read len=5 -> exactly one beat returned, rd_last=1.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access controller: FSM state encoding
// and response FIFO sizing.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } ctrl_state_t;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/mem_resp_fifo.sv
// Small synchronous show-ahead FIFO buffering read responses (data + last flag).
module mem_resp_fifo
    import mem_ctrl_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      din,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [WIDTH-1:0]      mem_reg [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_reg;
    logic [FIFO_PTR_W-1:0] rd_ptr_reg;
    logic [FIFO_CNT_W-1:0] count_reg;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count_reg == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_reg[rd_ptr_reg];

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg == FIFO_PTR_W'(gi))) begin
                mem_reg[gi] <= din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + FIFO_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + FIFO_PTR_W'(1);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + FIFO_CNT_W'(1);
                2'b01:   count_reg <= count_reg - FIFO_CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Burst memory access controller for a 1-cycle-latency synchronous SRAM.
// MEM_ACCESS_CTRL_BURST_EN enables multi-beat bursts; otherwise every command is one beat.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [DATA_WIDTH-1:0] wd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  mem_cen,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    ctrl_state_t           state_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [LEN_WIDTH-1:0]  rem_reg;
    logic                  mem_cen_reg;
    logic                  mem_wr_en_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_wdata_reg;
    logic [1:0]            rd_pipe_reg;
    logic [1:0]            rd_pipe_last_reg;

    logic [LEN_WIDTH-1:0]  cmd_rem;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic [FIFO_CNT_W-1:0] occupancy;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH:0]   fifo_dout;
    logic                  can_issue;
    logic                  last_beat;

`ifdef MEM_ACCESS_CTRL_BURST_EN
    assign cmd_rem = cmd_len;
    assign rd_last = rd_valid && fifo_dout[DATA_WIDTH];
`else
    assign cmd_rem = '0;
    assign rd_last = !rst;
    logic unused_cfg;
    assign unused_cfg = &{1'b0, cmd_len, fifo_dout[DATA_WIDTH]};
`endif

    assign cmd_ready = (state_reg == ST_IDLE) && !rst;
    assign wd_ready  = (state_reg == ST_WRITE) && !rst;
    assign rd_valid  = !fifo_empty && !rst;
    assign rd_data   = fifo_dout[DATA_WIDTH-1:0];

    assign mem_cen   = mem_cen_reg;
    assign mem_wr_en = mem_wr_en_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

    // Reads still in the pipeline already own a FIFO slot, so count them as occupied.
    assign occupancy = fifo_count + FIFO_CNT_W'(rd_pipe_reg[0]) + FIFO_CNT_W'(rd_pipe_reg[1]);
    assign can_issue = !fifo_full && (occupancy < FIFO_CNT_W'(FIFO_DEPTH));
    assign last_beat = (rem_reg == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            addr_reg         <= '0;
            rem_reg          <= '0;
            mem_cen_reg      <= 1'b1;
            mem_wr_en_reg    <= 1'b0;
            mem_addr_reg     <= '0;
            mem_wdata_reg    <= '0;
            rd_pipe_reg      <= '0;
            rd_pipe_last_reg <= '0;
        end else begin
            mem_cen_reg         <= 1'b1;
            mem_wr_en_reg       <= 1'b0;
            rd_pipe_reg         <= {rd_pipe_reg[0], 1'b0};
            rd_pipe_last_reg    <= {rd_pipe_last_reg[0], 1'b0};

            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_reg  <= cmd_addr;
                        rem_reg   <= cmd_rem;
                        state_reg <= cmd_wr ? ST_WRITE : ST_READ;
                    end
                end

                ST_WRITE: begin
                    if (wd_valid) begin
                        mem_cen_reg   <= 1'b0;
                        mem_wr_en_reg <= 1'b1;
                        mem_addr_reg  <= addr_reg;
                        mem_wdata_reg <= wd_data;
                        addr_reg      <= addr_reg + ADDR_WIDTH'(1);
                        if (last_beat) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            rem_reg <= rem_reg - LEN_WIDTH'(1);
                        end
                    end
                end

                ST_READ: begin
                    if (can_issue) begin
                        mem_cen_reg         <= 1'b0;
                        mem_addr_reg        <= addr_reg;
                        rd_pipe_reg[0]      <= 1'b1;
                        rd_pipe_last_reg[0] <= last_beat;
                        addr_reg            <= addr_reg + ADDR_WIDTH'(1);
                        if (last_beat) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            rem_reg <= rem_reg - LEN_WIDTH'(1);
                        end
                    end
                end

                ST_DRAIN: begin
                    if (rd_pipe_reg == 2'b00) begin
                        state_reg <= ST_IDLE;
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Stage 1 of the pipe marks the cycle in which mem_rdata holds the issued word.
    mem_resp_fifo #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_resp_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (rd_pipe_reg[1]),
        .din  ({rd_pipe_last_reg[1], mem_rdata}),
        .pop  (rd_valid && rd_ready),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: command table plus hand-written corner sequences,
// with scoreboards for memory writes and read responses.
module tb_mem_access_ctrl;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int LW = 4;
`ifdef MEM_ACCESS_CTRL_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          wd_valid;
    logic          wd_ready;
    logic [DW-1:0] wd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          mem_cen;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_access_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr   (cmd_wr),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wd_valid (wd_valid),
        .wd_ready (wd_ready),
        .wd_data  (wd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .mem_cen  (mem_cen),
        .mem_wr_en(mem_wr_en),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM with one cycle of read latency.
    logic [DW-1:0] mem_model [64];
    always @(posedge clk) begin
        if (mem_cen === 1'b0) begin
            if (mem_wr_en) mem_model[mem_addr] <= mem_wdata;
            else           mem_rdata <= mem_model[mem_addr];
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } rd_exp_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [DW-1:0] base;
        int            exp_beats;
    } vec_t;

    wr_exp_t       wr_q[$];
    rd_exp_t       rd_q[$];
    logic [DW-1:0] ref_mem [64];
    int            checks;
    int            errors;
    int            wr_beats;
    int            rd_beats;
    int            rd_issues;

    function automatic int beats(input logic [LW-1:0] len);
        return BURST ? int'(len) + 1 : 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: compare memory writes and read responses as they appear.
    always @(negedge clk) begin
        wr_exp_t we;
        rd_exp_t re;
        if (rst === 1'b0 && mem_cen === 1'b0 && mem_wr_en === 1'b1) begin
            wr_beats++;
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual addr=%0d data=%0h required no write", mem_addr, mem_wdata);
            end else begin
                we = wr_q.pop_front();
                if (mem_addr !== we.addr || mem_wdata !== we.data) begin
                    errors++;
                    $display("FAIL mem_write actual addr=%0d data=%0h required addr=%0d data=%0h",
                             mem_addr, mem_wdata, we.addr, we.data);
                end
            end
        end
        if (mem_cen === 1'b0 && mem_wr_en === 1'b0) rd_issues++;
        if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
            rd_beats++;
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rd actual data=%0h required no beat", rd_data);
            end else begin
                re = rd_q.pop_front();
                if (rd_data !== re.data || rd_last !== re.last) begin
                    errors++;
                    $display("FAIL rd_beat actual data=%0h last=%0b required data=%0h last=%0b",
                             rd_data, rd_last, re.data, re.last);
                end
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                            output bit ok);
        int      n;
        int      nb;
        rd_exp_t e;
        n  = 0;
        nb = beats(len);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = addr;
        cmd_len   = len;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (cmd_ready === 1'b1);
        if (!ok) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
        if (ok && !wr) begin
            for (int i = 0; i < nb; i++) begin
                e.data = ref_mem[addr + AW'(i)];
                e.last = (i == nb - 1);
                rd_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                               input logic [DW-1:0] base, input bit stall);
        int      nb;
        int      n;
        bit      ok;
        wr_exp_t e;
        nb = beats(len);
        send_cmd(1'b1, addr, len, ok);
        if (!ok) return;
        for (int i = 0; i < nb; i++) begin
            if (stall) begin
                wd_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            wd_valid = 1'b1;
            wd_data  = base + DW'(i);
            n = 0;
            @(negedge clk);
            while (wd_ready !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (wd_ready !== 1'b1) begin
                chk("wd_ready_timeout", 64'(wd_ready), 64'd1);
                wd_valid = 1'b0;
                return;
            end
            e.addr = addr + AW'(i);
            e.data = base + DW'(i);
            wr_q.push_back(e);
            ref_mem[e.addr] = e.data;
            @(posedge clk);
            #1;
        end
        wd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_rd_done(input string name);
        int n;
        n = 0;
        while (rd_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk(name, 64'(rd_q.size()), 64'd0);
    endtask

    task automatic read_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len, input string name);
        bit ok;
        send_cmd(1'b0, addr, len, ok);
        if (ok) wait_rd_done(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    localparam int NV = 8;
    vec_t vec [NV];

    initial begin
        int  wb0;
        int  rb0;
        int  ib0;
        int  n;
        bit  ok;
        checks    = 0;
        errors    = 0;
        wr_beats  = 0;
        rd_beats  = 0;
        rd_issues = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        wd_valid  = 1'b0;
        wd_data   = '0;
        rd_ready  = 1'b1;

        vec[0] = '{1'b1, 6'd5,  4'd3,  32'h0000_00A0, beats(4'd3)};
        vec[1] = '{1'b0, 6'd5,  4'd3,  32'h0,         beats(4'd3)};
        vec[2] = '{1'b1, 6'd62, 4'd3,  32'h0000_00B0, beats(4'd3)};
        vec[3] = '{1'b0, 6'd62, 4'd3,  32'h0,         beats(4'd3)};
        vec[4] = '{1'b1, 6'd20, 4'd0,  32'h0000_00C0, 1};
        vec[5] = '{1'b0, 6'd20, 4'd0,  32'h0,         1};
        vec[6] = '{1'b1, 6'd30, 4'd15, 32'h0000_0100, beats(4'd15)};
        vec[7] = '{1'b0, 6'd30, 4'd15, 32'h0,         beats(4'd15)};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_cen",   64'(mem_cen),   64'd1);
        chk("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rst_mem_addr",  64'(mem_addr),  64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_wd_ready",  64'(wd_ready),  64'd0);
        chk("rst_rd_valid",  64'(rd_valid),  64'd0);
        chk("rst_rd_last",   64'(rd_last),   64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;

        for (int v = 0; v < NV; v++) begin
            wb0 = wr_beats;
            rb0 = rd_beats;
            if (vec[v].wr) begin
                write_burst(vec[v].addr, vec[v].len, vec[v].base, 1'b0);
                chk($sformatf("vec%0d_wr_beats", v), 64'(wr_beats - wb0), 64'(vec[v].exp_beats));
            end else begin
                read_burst(vec[v].addr, vec[v].len, $sformatf("vec%0d_rd_done", v));
                chk($sformatf("vec%0d_rd_beats", v), 64'(rd_beats - rb0), 64'(vec[v].exp_beats));
            end
            $display("vec %0d wr=%0b addr=%0d len=%0d beats=%0d", v, vec[v].wr, vec[v].addr,
                     vec[v].len, vec[v].wr ? wr_beats - wb0 : rd_beats - rb0);
        end

        // Backpressure: responses must not be lost while the host stalls.
        rd_ready = 1'b0;
        ib0 = rd_issues;
        rb0 = rd_beats;
        send_cmd(1'b0, 6'd30, 4'd15, ok);
        repeat (20) @(posedge clk);
        #1;
        chk("bp_issues",   64'(rd_issues - ib0), BURST ? 64'd4 : 64'd1);
        chk("bp_cen_high", 64'(mem_cen),  64'd1);
        chk("bp_rd_valid", 64'(rd_valid), 64'd1);
        rd_ready = 1'b1;
        wait_rd_done("bp_drain");
        chk("bp_beats", 64'(rd_beats - rb0), 64'(beats(4'd15)));
        $display("backpressure read beats=%0d", rd_beats - rb0);

        // Write data arriving every other cycle.
        wb0 = wr_beats;
        write_burst(6'd40, 4'd3, 32'h0000_00D0, 1'b1);
        chk("stall_writes", 64'(wr_beats - wb0), 64'(beats(4'd3)));
        $display("stalled write beats=%0d", wr_beats - wb0);
        read_burst(6'd40, 4'd3, "stall_readback");

        // Reset in the middle of a read burst.
        rb0 = rd_beats;
        send_cmd(1'b0, 6'd30, 4'd7, ok);
        n = 0;
        while (rd_beats - rb0 < 1 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("rst_mid_first_beat", 64'(rd_beats - rb0 >= 1), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_rd_valid",  64'(rd_valid),  64'd0);
        chk("rst_mid_mem_cen",   64'(mem_cen),   64'd1);
        chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'd0);
        rd_q.delete();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_cmd_ready_after", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_fifo_flushed", 64'(rd_valid), 64'd0);
        $display("reset mid-read beats_before_reset=%0d", rd_beats - rb0);

        rb0 = rd_beats;
        read_burst(6'd5, 4'd3, "post_rst_rd_done");
        chk("post_rst_rd_beats", 64'(rd_beats - rb0), 64'(beats(4'd3)));
        $display("post-reset read beats=%0d", rd_beats - rb0);

        chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
        chk("rd_q_empty", 64'(rd_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
